// File: rtl/fp32_div.sv
// -----------------------------------------------------------------------------
// fp32_div : sequential IEEE-754 binary32 divider, result = a / b.
//
// Iterative restoring mantissa division. The block accepts one operation at a
// time with a valid/ready handshake on both the operand and the result side.
// Round-to-nearest-even, gradual underflow, canonical NaN 0xFFC00000.
//
// Parameters
//   BITS_PER_CYCLE : quotient bits retired per DIV cycle (1 or 2)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block idle, operands may be accepted
//   a          in   dividend, binary32
//   b          in   divisor, binary32
//   out_valid  out  result valid, held until accepted
//   out_ready  in   consumer accepts the result
//   result     out  quotient, binary32
//
// Configuration macro
//   FP32_DIV_FTZ_EN : when defined, subnormal inputs are treated as signed
//                     zero and results below 2^-126 are flushed to signed
//                     zero; the underflow shifter and the leading-zero
//                     normaliser are not built.
// -----------------------------------------------------------------------------
module fp32_div #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    localparam int          N_ITER    = 26 / BITS_PER_CYCLE;
    localparam logic [4:0]  LAST_CNT  = 5'(N_ITER - 1);
    localparam logic [31:0] CANON_NAN = 32'hFFC0_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_DIV  = 3'd2,
        S_RND  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [30:0]       r_a;
    logic [30:0]       r_b;
    logic              r_sign;
    logic signed [9:0] r_ze;
    logic [25:0]       r_rem;
    logic [23:0]       r_bm;
    logic [25:0]       r_q;
    logic [4:0]        r_cnt;
    logic [31:0]       r_result;
    logic              r_out_valid;
    logic              r_in_ready;
`ifdef FP32_DIV_FTZ_EN
    logic              r_flush;
    logic              w_norm_flush;
`endif

    logic              w_accept;
    logic              w_special;
    logic [31:0]       w_special_res;
    logic [25:0]       w_norm_rem;
    logic [23:0]       w_norm_bm;
    logic signed [9:0] w_norm_ze;
    logic [25:0]       w_div_rem;
    logic [25:0]       w_div_q;
    logic [31:0]       w_rnd_result;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign w_accept  = in_valid && r_in_ready;

    // Unbiased exponent; a zero exponent field means 2^-126 (subnormal).
    function automatic logic signed [9:0] unbias(input logic [7:0] e);
        if (e == 8'd0) begin
            return -10'sd126;
        end else begin
            return $signed({2'b00, e}) - 10'sd127;
        end
    endfunction

`ifndef FP32_DIV_FTZ_EN
    // Leading-zero count of a non-zero 24-bit mantissa.
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end else begin
                n = n;
            end
        end
        return n;
    endfunction
`endif

    // Classify the incoming operands; specials bypass the divider entirely.
    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
`ifdef FP32_DIV_FTZ_EN
        a_zero = !(|a[30:23]);
        b_zero = !(|b[30:23]);
`else
        a_zero = !(|a[30:0]);
        b_zero = !(|b[30:0]);
`endif
        s             = a[31] ^ b[31];
        w_special     = 1'b1;
        w_special_res = CANON_NAN;
        if (a_nan || b_nan) begin
            w_special_res = CANON_NAN;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            w_special_res = CANON_NAN;
        end else if (a_inf || b_zero) begin
            w_special_res = {s, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
            w_special_res = {s, 31'd0};
        end else begin
            w_special     = 1'b0;
            w_special_res = CANON_NAN;
        end
    end

    // Normalise both mantissas and pre-shift the dividend so the quotient is in [1,2).
    always_comb begin
        logic [23:0]       am, bm;
        logic signed [9:0] ae, be, ze;
`ifndef FP32_DIV_FTZ_EN
        logic [4:0]        la, lb;
`endif
        am = {|r_a[30:23], r_a[22:0]};
        bm = {|r_b[30:23], r_b[22:0]};
        ae = unbias(r_a[30:23]);
        be = unbias(r_b[30:23]);
`ifndef FP32_DIV_FTZ_EN
        la = lzc24(am);
        lb = lzc24(bm);
        am = am << la;
        bm = bm << lb;
        ae = ae - $signed({5'd0, la});
        be = be - $signed({5'd0, lb});
`endif
        ze = ae - be;
        if (am < bm) begin
            w_norm_rem = {1'b0, am, 1'b0};
            ze         = ze - 10'sd1;
        end else begin
            w_norm_rem = {2'b00, am};
        end
        w_norm_bm = bm;
        w_norm_ze = ze;
`ifdef FP32_DIV_FTZ_EN
        w_norm_flush = (ze < -10'sd126);
`endif
    end

    // One DIV cycle: BITS_PER_CYCLE restoring subtract-and-shift steps.
    always_comb begin
        logic [25:0] rem, q;
        rem = r_rem;
        q   = r_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem >= {2'b00, r_bm}) begin
                rem = rem - {2'b00, r_bm};
                q   = {q[24:0], 1'b1};
            end else begin
                q   = {q[24:0], 1'b0};
            end
            rem = {rem[24:0], 1'b0};
        end
        w_div_rem = rem;
        w_div_q   = q;
    end

    // Denormalise (if needed), round to nearest even and pack the result.
    // q[25] is the integer bit, q[24:2] the fraction, q[1] guard, q[0] round.
    always_comb begin
        logic [25:0]       q;
        logic              sticky, inc;
        logic signed [9:0] ze;
        logic [24:0]       m25;
        logic [23:0]       m;
        logic [31:0]       res;
`ifndef FP32_DIV_FTZ_EN
        logic [9:0]        sh;
        logic [25:0]       mask;
`endif
        q      = r_q;
        sticky = |r_rem;
        ze     = r_ze;
`ifndef FP32_DIV_FTZ_EN
        sh   = 10'd0;
        mask = 26'd0;
        if (ze < -10'sd126) begin
            sh = 10'(-10'sd126 - ze);
            if (sh >= 10'd26) begin
                sticky = sticky | (|q);
                q      = 26'd0;
            end else begin
                mask   = (26'd1 << sh[4:0]) - 26'd1;
                sticky = sticky | (|(q & mask));
                q      = q >> sh[4:0];
            end
            ze = -10'sd126;
        end else begin
            sh = 10'd0;
        end
`endif
        inc = q[1] & (q[0] | sticky | q[2]);
        m25 = {1'b0, q[25:2]} + {24'd0, inc};
        // Carry out of the hidden bit: renormalise.
        if (m25[24]) begin
            m  = m25[24:1];
            ze = ze + 10'sd1;
        end else begin
            m  = m25[23:0];
        end
        if (ze > 10'sd127) begin
            res = {r_sign, 8'hFF, 23'd0};
        end else if (m == 24'd0) begin
            res = {r_sign, 31'd0};
        end else if (!m[23]) begin
            res = {r_sign, 8'h00, m[22:0]};
        end else begin
            res = {r_sign, 8'(ze + 10'sd127), m[22:0]};
        end
`ifdef FP32_DIV_FTZ_EN
        if (r_flush) begin
            w_rnd_result = {r_sign, 31'd0};
        end else begin
            w_rnd_result = res;
        end
`else
        w_rnd_result = res;
`endif
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_special ? S_OUT : S_NORM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_NORM: w_state_next = S_DIV;
            S_DIV: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = S_RND;
                end else begin
                    w_state_next = S_DIV;
                end
            end
            S_RND: w_state_next = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_OUT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake flags are registered copies of the state they announce.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_OUT);
        end
    end

    // Operand capture, divider iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 31'd0;
            r_b      <= 31'd0;
            r_sign   <= 1'b0;
            r_ze     <= 10'sd0;
            r_rem    <= 26'd0;
            r_bm     <= 24'd0;
            r_q      <= 26'd0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
`ifdef FP32_DIV_FTZ_EN
            r_flush  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= a[30:0];
                        r_b    <= b[30:0];
                        r_sign <= a[31] ^ b[31];
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_NORM: begin
                    r_rem   <= w_norm_rem;
                    r_bm    <= w_norm_bm;
                    r_ze    <= w_norm_ze;
                    r_q     <= 26'd0;
                    r_cnt   <= 5'd0;
`ifdef FP32_DIV_FTZ_EN
                    r_flush <= w_norm_flush;
`endif
                end
                S_DIV: begin
                    r_rem <= w_div_rem;
                    r_q   <= w_div_q;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_RND: begin
                    r_result <= w_rnd_result;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
